led_counter: RTL and testbench
==============================

LED_COUNTER -- requirements
Module: led_counter

Interface
REQ-001 Parameter PRESCALE, default 30, means the number of clk rising edges per LED count step (30 frames = 0.5 s at 60 Hz when clk is vblank).
REQ-002 Parameter WIDTH, default 5, means the width of the LED count and output bus.
REQ-003 Port clk  input  1  the single clock; rising-edge active; in the system it is driven by the video vblank signal, so one edge equals one frame.
REQ-004 Port clr  input  1  reset; synchronous, active-high.
REQ-005 Port leds  output  WIDTH  LED count value; bit WIDTH-1 drives LED1 (MSB), bit 0 drives LED5 (LSB).
REQ-006 Port order SHALL be clk, leds, clr, so that existing two-port positional instances (clk, leds) remain valid.

Function
REQ-007 An internal prescaler SHALL count clk edges from 0 to PRESCALE-1, with width ceil(log2(PRESCALE)), minimum 1 bit.
REQ-008 When the prescaler equals PRESCALE-1, it SHALL wrap to 0 on the next edge, and the LED count SHALL increment by 1 on that same edge.
REQ-009 On every other edge the prescaler SHALL increment by 1 and the LED count SHALL hold.
REQ-010 The LED count SHALL be unsigned WIDTH bits and SHALL wrap from 2^WIDTH-1 to 0 (31 to 0 for the default) with no saturation or flag.
REQ-011 leds SHALL be driven directly from the LED count register, with no combinational path from any input.
REQ-012 Step latency: leds SHALL first change on the PRESCALE-th rising edge after reset release, with no glitch between steps.
REQ-013 With PRESCALE=1, the prescaler SHALL be constant 0 and leds SHALL increment on every edge.
REQ-014 PRESCALE < 1 is illegal; elaboration SHALL fail via a parameter check.

Reset
REQ-015 While clr=1 at a rising edge, the prescaler SHALL be set to 0 and leds to 0; clr has priority over counting.
REQ-016 clr asserted mid-count SHALL discard partial prescale progress; after release, the first step SHALL again occur PRESCALE edges later.
REQ-017 No asynchronous reset path SHALL exist; registers SHALL also carry initial value 0 for FPGA power-up.

Structure
REQ-018 No shared package is required; PRESCALE and WIDTH are module-local parameters.
REQ-019 The prescaler SHALL be one sub-module, led_prescaler (ports clk, clr, tick; parameter PRESCALE), emitting a one-cycle tick at terminal count; led_counter SHALL add the WIDTH-bit count register.
REQ-020 pll is a separate vendor-primitive wrapper (ports: reference clock in, PLL clock out, locked out) and is outside this block; led_counter SHALL NOT depend on it.

Verification (PRESCALE=4, WIDTH=5 unless stated)
REQ-021 clr=1 for 2 edges, then release -> leds=0 through edge 3, and leds=1 after the 4th edge.
REQ-022 Run 128 edges after release -> leds=31 after edge 124, and leds=0 after edge 128 (wrap).
REQ-023 Assert clr for 1 edge when the prescaler is at 2 and leds=5 -> leds=0 immediately; the next increment occurs 4 edges after release.
REQ-024 PRESCALE=1 -> leds = 1, 2, 3 on successive edges after reset.
REQ-025 Default parameters (PRESCALE=30), 60 edges after reset -> leds=2; leds held constant between steps (no intermediate change).
REQ-026 Hold clr=1 for 100 edges -> leds stays 0 throughout.

Source files
------------

// File: rtl/led_counter_pkg.sv
// Shared helpers for the LED step counter: sizing of the frame prescaler.
package led_counter_pkg;

    // Bits needed to hold 0..prescale-1, never less than one bit.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Frame prescaler: counts clk edges 0..PRESCALE-1 and flags the terminal count.
module led_prescaler
    import led_counter_pkg::*;
#(
    parameter int PRESCALE = 30
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] TERMINAL = PW'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("led_prescaler: PRESCALE must be at least 1");
        end
    endgenerate

    // With PRESCALE=1 the terminal count is 0, so the register stays at 0.
    logic [PW-1:0] cnt_reg = '0;
    logic [PW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + PW'(1);
        if (cnt_reg == TERMINAL) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = (cnt_reg == TERMINAL);

endmodule

// File: rtl/led_counter.sv
// LED step counter: advances a WIDTH-bit count once every PRESCALE clk edges.
module led_counter
    import led_counter_pkg::*;
#(
    parameter int PRESCALE = 30,
    parameter int WIDTH    = 5
) (
    input  logic             clk,
    output logic [WIDTH-1:0] leds,
    input  logic             clr
);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("led_counter: PRESCALE must be at least 1");
        end
    endgenerate

    logic             tick;
    logic [WIDTH-1:0] count_reg = '0;
    logic [WIDTH-1:0] count_next;

    led_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .clr (clr),
        .tick(tick)
    );

    // Natural unsigned wrap from all-ones back to zero.
    always_comb begin
        count_next = count_reg;
        if (tick) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Bit WIDTH-1 drives LED1, bit 0 drives the last LED; straight from the register.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led
            assign leds[gi] = count_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_led_counter.sv
// Directed bench for led_counter at PRESCALE=4, PRESCALE=1 and the default PRESCALE=30.
module tb_led_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [4:0] leds_p4;
    logic [4:0] leds_p1;
    logic [4:0] leds_p30;

    int checks = 0;
    int errors = 0;

    led_counter #(.PRESCALE(4), .WIDTH(5)) dut_p4 (
        .clk (clk),
        .leds(leds_p4),
        .clr (clr)
    );

    led_counter #(.PRESCALE(1), .WIDTH(5)) dut_p1 (
        .clk (clk),
        .leds(leds_p1),
        .clr (clr)
    );

    led_counter dut_p30 (
        .clk (clk),
        .leds(leds_p30),
        .clr (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [4:0] exp_p4;
        logic [4:0] exp_p1;
    } vec_t;

    vec_t vecs[10];

    task automatic step(input logic c);
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: leds=%0d expected %0d", name, idx, act, exp);
        end else begin
            $display("ok   %s[%0d]: leds=%0d", name, idx, act);
        end
    endtask

    initial begin
        // Reset for two edges, then release: PRESCALE=4 steps on the 4th edge,
        // PRESCALE=1 steps on every edge.
        vecs[0] = '{1'b1, 5'd0, 5'd0};
        vecs[1] = '{1'b1, 5'd0, 5'd0};
        vecs[2] = '{1'b0, 5'd0, 5'd1};
        vecs[3] = '{1'b0, 5'd0, 5'd2};
        vecs[4] = '{1'b0, 5'd0, 5'd3};
        vecs[5] = '{1'b0, 5'd1, 5'd4};
        vecs[6] = '{1'b0, 5'd1, 5'd5};
        vecs[7] = '{1'b0, 5'd1, 5'd6};
        vecs[8] = '{1'b0, 5'd1, 5'd7};
        vecs[9] = '{1'b0, 5'd2, 5'd8};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].clr);
            check("vec_p4", i, leds_p4, vecs[i].exp_p4);
            check("vec_p1", i, leds_p1, vecs[i].exp_p1);
        end

        // Wrap: 128 edges after release; P4 hits 31 at edge 124 and 0 at 128.
        step(1'b1);
        check("wrap_reset", 0, leds_p4, 5'd0);
        for (int n = 1; n <= 128; n++) begin
            step(1'b0);
            check("wrap_p4", n, leds_p4, 5'((n / 4) % 32));
            check("wrap_p1", n, leds_p1, 5'(n % 32));
            if (n == 124) check("wrap_p4_at124", n, leds_p4, 5'd31);
            if (n == 128) check("wrap_p4_at128", n, leds_p4, 5'd0);
        end

        // Mid-count clear with P4 at leds=5, prescaler=2 (22 edges after release).
        step(1'b1);
        for (int n = 1; n <= 22; n++) step(1'b0);
        check("mid_before", 22, leds_p4, 5'd5);
        step(1'b1);
        check("mid_clr", 0, leds_p4, 5'd0);
        for (int n = 1; n <= 4; n++) begin
            step(1'b0);
            check("mid_after", n, leds_p4, (n == 4) ? 5'd1 : 5'd0);
        end

        // Default PRESCALE=30: 0 for edges 1..29, 1 for 30..59, 2 at 60.
        step(1'b1);
        check("p30_reset", 0, leds_p30, 5'd0);
        for (int n = 1; n <= 60; n++) begin
            step(1'b0);
            check("p30_run", n, leds_p30, (n < 30) ? 5'd0 : ((n < 60) ? 5'd1 : 5'd2));
        end

        // Long clear: every counter stays at zero for 100 edges.
        for (int n = 1; n <= 100; n++) begin
            step(1'b1);
            if (leds_p4 !== 5'd0 || leds_p1 !== 5'd0 || leds_p30 !== 5'd0) begin
                check("hold_p4", n, leds_p4, 5'd0);
                check("hold_p1", n, leds_p1, 5'd0);
                check("hold_p30", n, leds_p30, 5'd0);
            end else begin
                checks++;
            end
        end
        check("hold_end_p4", 100, leds_p4, 5'd0);
        check("hold_end_p1", 100, leds_p1, 5'd0);
        check("hold_end_p30", 100, leds_p30, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
